// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the CPU data port (D)
// and the CPU instruction-fetch port (I). The data port always has priority.
// A three-state FSM (IDLE, D_WAIT, I_WAIT) issues one registered request at a
// time and holds it until the memory answers with MemReady.
// Optional feature: define ARB_IBUF_EN to add a single-entry instruction
// buffer that keeps the last fetched word across CPU advances, so a repeated
// fetch of the same address completes without a memory access.
module mem_arbiter (
   input  logic        clock,
   input  logic        reset,
   input  logic        CRead0,
   input  logic        CWrite0,
   input  logic [31:0] CAddr0,
   input  logic [31:0] CWriteData0,
   output logic [31:0] CReadData0,
   input  logic [31:0] CAddr1,
   output logic [31:0] CReadData1,
   output logic        stall,
   output logic        MemReq,
   output logic        MemWe,
   output logic [31:0] MemAddr,
   output logic [31:0] MemWData,
   input  logic [31:0] MemRData,
   input  logic        MemReady
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      D_WAIT = 2'd1,
      I_WAIT = 2'd2
   } state_t;

   state_t      state_reg, state_next;

   logic        mem_req_reg;
   logic        mem_we_reg;
   logic [31:0] mem_addr_reg;
   logic [31:0] mem_wdata_reg;
   logic [31:0] d_data_reg;
   logic [31:0] i_data_reg;
   logic        d_done_reg;

   logic        dreq;
   logic        d_sat;
   logic        i_sat;
   logic        load_d;
   logic        load_i;
   logic        d_complete;
   logic        i_complete;

   // Byte-offset bits of the CPU addresses never reach memory (word access).
   logic        unused_addr_bits;
   assign unused_addr_bits = ^{CAddr0[1:0], CAddr1[1:0]};

   assign dreq  = CRead0 | CWrite0;
   assign d_sat = ~dreq | d_done_reg;

`ifdef ARB_IBUF_EN
   logic        ibuf_valid_reg;
   logic [29:0] ibuf_tag_reg;
   logic [31:0] ibuf_data_reg;
   logic        ibuf_hit;

   // The instruction is satisfied only by a buffer hit on the current address.
   assign ibuf_hit   = ibuf_valid_reg & (ibuf_tag_reg == CAddr1[31:2]);
   assign i_sat      = ibuf_hit;
   assign CReadData1 = ibuf_hit ? ibuf_data_reg : i_data_reg;

   // Buffer fill on fetch completion; invalidate when a D write hits the tag.
   always_ff @(posedge clock) begin
      if (reset) begin
         ibuf_valid_reg <= 1'b0;
         ibuf_tag_reg   <= '0;
         ibuf_data_reg  <= '0;
      end else if (i_complete) begin
         ibuf_valid_reg <= 1'b1;
         ibuf_tag_reg   <= mem_addr_reg[31:2];
         ibuf_data_reg  <= MemRData;
      end else if (d_complete && mem_we_reg && (ibuf_tag_reg == mem_addr_reg[31:2])) begin
         ibuf_valid_reg <= 1'b0;
      end
   end
`else
   logic        i_flag_reg;

   // Without a buffer the fetch is satisfied only until the CPU advances.
   assign i_sat      = i_flag_reg;
   assign CReadData1 = i_data_reg;

   // I-satisfied flag: set on fetch completion, cleared when the CPU advances.
   always_ff @(posedge clock) begin
      if (reset) begin
         i_flag_reg <= 1'b0;
      end else if (i_complete) begin
         i_flag_reg <= 1'b1;
      end else if (!stall) begin
         i_flag_reg <= 1'b0;
      end
   end
`endif

   // Reset forces a stall even if the FSM happens to sit in IDLE.
   assign stall = reset | ~((state_reg == IDLE) & d_sat & i_sat);

   assign MemReq     = mem_req_reg;
   assign MemWe      = mem_we_reg;
   assign MemAddr    = mem_addr_reg;
   assign MemWData   = mem_wdata_reg;
   assign CReadData0 = d_data_reg;

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: D before I; wait states leave only on MemReady.
   always_comb begin
      state_next = state_reg;
      load_d     = 1'b0;
      load_i     = 1'b0;
      d_complete = 1'b0;
      i_complete = 1'b0;
      case (state_reg)
         IDLE: begin
            if (dreq && !d_done_reg) begin
               state_next = D_WAIT;
               load_d     = 1'b1;
            end else if (!i_sat) begin
               state_next = I_WAIT;
               load_i     = 1'b1;
            end
         end
         D_WAIT: begin
            if (MemReady) begin
               state_next = IDLE;
               d_complete = 1'b1;
            end
         end
         I_WAIT: begin
            if (MemReady) begin
               state_next = IDLE;
               i_complete = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Registered memory request; held stable for the whole wait state.
   always_ff @(posedge clock) begin
      if (reset) begin
         mem_req_reg   <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
      end else if (load_d) begin
         mem_req_reg   <= 1'b1;
         mem_we_reg    <= CWrite0;
         mem_addr_reg  <= {CAddr0[31:2], 2'b00};
         mem_wdata_reg <= CWriteData0;
      end else if (load_i) begin
         mem_req_reg   <= 1'b1;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= {CAddr1[31:2], 2'b00};
      end else if (d_complete || i_complete) begin
         mem_req_reg   <= 1'b0;
      end
   end

   // D completion flag and read-data capture; flag drops when the CPU advances.
   always_ff @(posedge clock) begin
      if (reset) begin
         d_done_reg <= 1'b0;
         d_data_reg <= '0;
      end else if (d_complete) begin
         d_done_reg <= 1'b1;
         if (!mem_we_reg) begin
            d_data_reg <= MemRData;
         end
      end else if (!stall) begin
         d_done_reg <= 1'b0;
      end
   end

   // Fetched instruction register, reloaded only on fetch completion.
   always_ff @(posedge clock) begin
      if (reset) begin
         i_data_reg <= '0;
      end else if (i_complete) begin
         i_data_reg <= MemRData;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. Memory responses are
// driven by hand per scenario. Works with or without ARB_IBUF_EN.
module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        CRead0;
   logic        CWrite0;
   logic [31:0] CAddr0;
   logic [31:0] CWriteData0;
   logic [31:0] CReadData0;
   logic [31:0] CAddr1;
   logic [31:0] CReadData1;
   logic        stall;
   logic        MemReq;
   logic        MemWe;
   logic [31:0] MemAddr;
   logic [31:0] MemWData;
   logic [31:0] MemRData;
   logic        MemReady;

   int n_tests = 0;
   int n_fail  = 0;

   mem_arbiter dut (
      .clock       (clock),
      .reset       (reset),
      .CRead0      (CRead0),
      .CWrite0     (CWrite0),
      .CAddr0      (CAddr0),
      .CWriteData0 (CWriteData0),
      .CReadData0  (CReadData0),
      .CAddr1      (CAddr1),
      .CReadData1  (CReadData1),
      .stall       (stall),
      .MemReq      (MemReq),
      .MemWe       (MemWe),
      .MemAddr     (MemAddr),
      .MemWData    (MemWData),
      .MemRData    (MemRData),
      .MemReady    (MemReady)
   );

   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports mismatches.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge (input drive point).
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset       = 1'b1;
      CRead0      = 1'b0;
      CWrite0     = 1'b0;
      CAddr0      = 32'h0;
      CWriteData0 = 32'h0;
      CAddr1      = 32'h0;
      MemRData    = 32'h0;
      MemReady    = 1'b0;

      // Reset state
      step();
      @(negedge clock);
      check("rst_memreq", {31'b0, MemReq}, 32'd0);
      check("rst_memwe", {31'b0, MemWe}, 32'd0);
      check("rst_memaddr", MemAddr, 32'h0);
      check("rst_stall", {31'b0, stall}, 32'd1);
      check("rst_rd0", CReadData0, 32'h0);
      check("rst_rd1", CReadData1, 32'h0);
      $display("[TB] txn reset");

      // Scenario 1: cold I fetch of 0x0
      step();
      reset = 1'b0;
      @(negedge clock);
      check("cold_stall_c1", {31'b0, stall}, 32'd1);
      check("cold_noreq_c1", {31'b0, MemReq}, 32'd0);
      step();
      @(negedge clock);
      check("cold_req", {31'b0, MemReq}, 32'd1);
      check("cold_addr", MemAddr, 32'h0);
      check("cold_we", {31'b0, MemWe}, 32'd0);
      check("cold_stall_c2", {31'b0, stall}, 32'd1);
      MemRData = 32'h2008_0005;
      MemReady = 1'b1;
      step();
      MemReady = 1'b0;
      @(negedge clock);
      check("cold_stall_done", {31'b0, stall}, 32'd0);
      check("cold_rd1", CReadData1, 32'h2008_0005);
      check("cold_req_done", {31'b0, MemReq}, 32'd0);
`ifdef ARB_IBUF_EN
      step();
      @(negedge clock);
      check("ibuf_repeat_stall", {31'b0, stall}, 32'd0);
      check("ibuf_repeat_noreq", {31'b0, MemReq}, 32'd0);
`endif
      $display("[TB] txn cold_fetch addr=0x0 data=%h", CReadData1);

      // Scenario 2: D read 0x100 and I miss 0x4 together; D first
      step();
      CRead0 = 1'b1;
      CAddr0 = 32'h0000_0103;
      CAddr1 = 32'h0000_0004;
      @(negedge clock);
      check("dri_stall_idle", {31'b0, stall}, 32'd1);
      check("dri_noreq_idle", {31'b0, MemReq}, 32'd0);
      step();
      @(negedge clock);
      check("dri_d_req", {31'b0, MemReq}, 32'd1);
      check("dri_d_addr", MemAddr, 32'h0000_0100);
      check("dri_d_we", {31'b0, MemWe}, 32'd0);
      MemRData = 32'hDEAD_BEEF;
      MemReady = 1'b1;
      step();
      MemReady = 1'b0;
      @(negedge clock);
      check("dri_rd0", CReadData0, 32'hDEAD_BEEF);
      check("dri_stall_mid", {31'b0, stall}, 32'd1);
      check("dri_noreq_mid", {31'b0, MemReq}, 32'd0);
      step();
      @(negedge clock);
      check("dri_i_req", {31'b0, MemReq}, 32'd1);
      check("dri_i_addr", MemAddr, 32'h0000_0004);
      check("dri_i_we", {31'b0, MemWe}, 32'd0);
      check("dri_stall_iwait", {31'b0, stall}, 32'd1);
      MemRData = 32'h8C01_0000;
      MemReady = 1'b1;
      step();
      MemReady = 1'b0;
      @(negedge clock);
      check("dri_stall_done", {31'b0, stall}, 32'd0);
      check("dri_rd1", CReadData1, 32'h8C01_0000);
      check("dri_rd0_hold", CReadData0, 32'hDEAD_BEEF);
      $display("[TB] txn d_read_then_i_fetch d=%h i=%h", CReadData0, CReadData1);

      // Scenarios 3/4: D write to 0x4 with a 5-cycle slow memory
      step();
      CRead0      = 1'b0;
      CWrite0     = 1'b1;
      CAddr0      = 32'h0000_0004;
      CWriteData0 = 32'h1234_5678;
      @(negedge clock);
      check("wr_stall_idle", {31'b0, stall}, 32'd1);
      step();
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("wr_hold_req", {31'b0, MemReq}, 32'd1);
         check("wr_hold_addr", MemAddr, 32'h0000_0004);
         check("wr_hold_we", {31'b0, MemWe}, 32'd1);
         check("wr_hold_wdata", MemWData, 32'h1234_5678);
         check("wr_hold_stall", {31'b0, stall}, 32'd1);
         step();
      end
      @(negedge clock);
      MemRData = 32'h0BAD_F00D;
      MemReady = 1'b1;
      step();
      MemReady = 1'b0;
      @(negedge clock);
      check("wr_stall_after", {31'b0, stall}, 32'd1);
      check("wr_noreq_after", {31'b0, MemReq}, 32'd0);
      check("wr_rd0_unchanged", CReadData0, 32'hDEAD_BEEF);
      step();
      @(negedge clock);
      check("refetch_req", {31'b0, MemReq}, 32'd1);
      check("refetch_addr", MemAddr, 32'h0000_0004);
      check("refetch_we", {31'b0, MemWe}, 32'd0);
      MemRData = 32'h1234_5678;
      MemReady = 1'b1;
      step();
      MemReady = 1'b0;
      @(negedge clock);
      check("refetch_stall", {31'b0, stall}, 32'd0);
      check("refetch_rd1", CReadData1, 32'h1234_5678);
      $display("[TB] txn d_write addr=0x4 data=12345678 then refetch");

      // Scenario 5: reset in I_WAIT concurrent with MemReady
      step();
      CWrite0 = 1'b0;
      CAddr1  = 32'h0000_0008;
      @(negedge clock);
      check("rstw_stall_idle", {31'b0, stall}, 32'd1);
      step();
      @(negedge clock);
      check("rstw_req", {31'b0, MemReq}, 32'd1);
      check("rstw_addr", MemAddr, 32'h0000_0008);
      reset    = 1'b1;
      MemRData = 32'hFFFF_FFFF;
      MemReady = 1'b1;
      #1;
      check("rstw_stall_in_reset", {31'b0, stall}, 32'd1);
      step();
      reset    = 1'b0;
      MemReady = 1'b0;
      CAddr1   = 32'h0000_0004;
      @(negedge clock);
      check("rstw_noreq", {31'b0, MemReq}, 32'd0);
      check("rstw_rd1", CReadData1, 32'h0);
      check("rstw_rd0", CReadData0, 32'h0);
      check("rstw_stall_ibuf_inv", {31'b0, stall}, 32'd1);
      step();
      @(negedge clock);
      check("rstw_fetch_req", {31'b0, MemReq}, 32'd1);
      check("rstw_fetch_addr", MemAddr, 32'h0000_0004);
      MemRData = 32'h1111_1111;
      MemReady = 1'b1;
      step();
      MemReady = 1'b0;
      @(negedge clock);
      check("rstw_fetch_stall", {31'b0, stall}, 32'd0);
      check("rstw_fetch_rd1", CReadData1, 32'h1111_1111);
      $display("[TB] txn reset_in_i_wait");

      // Scenario 6: read and write both requested -> write
      step();
      CRead0      = 1'b1;
      CWrite0     = 1'b1;
      CAddr0      = 32'h0000_0008;
      CWriteData0 = 32'hCAFE_F00D;
      @(negedge clock);
      check("rw_stall_idle", {31'b0, stall}, 32'd1);
      step();
      @(negedge clock);
      check("rw_req", {31'b0, MemReq}, 32'd1);
      check("rw_we", {31'b0, MemWe}, 32'd1);
      check("rw_addr", MemAddr, 32'h0000_0008);
      check("rw_wdata", MemWData, 32'hCAFE_F00D);
      MemRData = 32'h5555_5555;
      MemReady = 1'b1;
      step();
      MemReady = 1'b0;
      @(negedge clock);
      check("rw_noreq_after", {31'b0, MemReq}, 32'd0);
      check("rw_rd0_not_loaded", CReadData0, 32'h0);
      $display("[TB] txn read_write_collision addr=0x8");

      step();
      CRead0  = 1'b0;
      CWrite0 = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named `clock` and `reset`.
REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `CRead0` in 1: CPU data-port read request.
- `CWrite0` in 1: CPU data-port write request.
- `CAddr0` in 32: data byte address.
- `CWriteData0` in 32: data to write.
- `CReadData0` out 32: data read result.
- `CAddr1` in 32: instruction fetch byte address.
- `CReadData1` out 32: fetched instruction.
- `stall` out 1: freeze CPU pipeline.
- `MemReq` out 1: memory request, registered.
- `MemWe` out 1: request is a write, registered.
- `MemAddr` out 32: word address, bits [1:0] = 00, registered.
- `MemWData` out 32: write data, registered.
- `MemRData` in 32: memory read data.
- `MemReady` in 1: memory completes the current request this cycle.

Function
REQ-003 The block SHALL share one single-ported memory between the CPU data port (D) and the CPU instruction port (I).
REQ-004 The block SHALL use FSM states IDLE, D_WAIT and I_WAIT; MemReq SHALL be 1 exactly in D_WAIT and I_WAIT.
REQ-005 Define the following terms:
- dreq = CRead0 | CWrite0.
- d_sat = ~dreq | d_done.
- i_sat = I-satisfied (REQ-010/REQ-017).
REQ-006 The combinational `stall` output SHALL equal ~(state==IDLE & d_sat & i_sat).
REQ-007 In IDLE, the next state SHALL be chosen as follows:
- If dreq & ~d_done: go to D_WAIT; load MemAddr={CAddr0[31:2],00}, MemWe=CWrite0, MemWData=CWriteData0.
- Else if ~i_sat: go to I_WAIT; load MemAddr={CAddr1[31:2],00}, MemWe=0.
- Otherwise: stay in IDLE.
- D always has priority over I.
REQ-008 In D_WAIT or I_WAIT, the FSM SHALL hold all Mem* outputs until MemReady=1, then return to IDLE on the next edge with MemReq=0.
REQ-009 On D completion, the block SHALL set d_done=1; on a read, it SHALL also load CReadData0 from MemRData.
REQ-010 On I completion, the block SHALL load the I data register from MemRData and set I-satisfied.
REQ-011 d_done and the non-buffered I-satisfied flag SHALL clear at every edge where stall=0, so the CPU's next request is served fresh.
REQ-012 If CRead0 and CWrite0 are both 1, the block SHALL perform a write (MemWe=1).
REQ-013 CReadData0 and CReadData1 SHALL hold their last loaded values until reloaded.
REQ-014 Minimum latency SHALL be:
- I satisfied, no D request: stall=0 in the same cycle.
- Otherwise: each memory access costs 1 IDLE cycle plus N wait cycles, where N ≥ 1 (MemReady sampled in the wait state).
REQ-015 The block SHALL never issue a new MemReq while a request is outstanding.
REQ-016 MemReady sampled in IDLE SHALL be ignored.

Reset
REQ-017 While reset=1, the block SHALL force:
- state=IDLE, MemReq=0, MemWe=0, MemAddr=0, MemWData=0;
- CReadData0=0, CReadData1=0;
- d_done=0, I-satisfied=0, instruction buffer valid=0;
- stall=1.
REQ-018 Reset asserted in D_WAIT or I_WAIT SHALL abandon the request: MemReq=0 after the edge, and any concurrent MemReady/MemRData SHALL be discarded.

Configuration
REQ-019 With macro ARB_IBUF_EN defined, the block SHALL include a single-entry instruction buffer:
- Buffer contents: valid bit, tag[29:0], data[31:0].
- Hit condition: i_sat = valid & (tag==CAddr1[31:2]); on a hit, CReadData1 = buffer data.
- The buffer SHALL persist across stall=0 edges.
- An I completion SHALL fill the buffer (valid=1, tag=MemAddr[31:2]).
- A D write completing to address tag==MemAddr[31:2] SHALL clear valid.
REQ-020 Without ARB_IBUF_EN, there SHALL be no buffer: i_sat is the I-satisfied flag, which clears per REQ-011, so every fetch accesses memory.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Cold I fetch after reset: CAddr1=0x0, memory returns 0x20080005 with MemReady on the first wait cycle. Required: stall=1 for 2 cycles, then stall=0 with CReadData1=0x20080005. With ARB_IBUF_EN, a repeat of CAddr1=0x0 gives stall=0 immediately with no MemReq.
- Simultaneous D read at 0x100 (mem=0xDEADBEEF) and I miss at 0x4. Required: D_WAIT is served before I_WAIT, then CReadData0=0xDEADBEEF; stall stays 1 until both complete.
- D write 0x12345678 to 0x4, with ARB_IBUF_EN and a buffer holding tag 0x4>>2. Required: MemWe=1 and MemWData=0x12345678; the buffer is invalidated; the next fetch of 0x4 issues MemReq.
- MemReady held low for 5 cycles in D_WAIT. Required: MemReq, MemAddr and MemWe stay stable and stall stays 1 for all 5 cycles.
- Reset asserted in I_WAIT in the same cycle as MemReady=1 with MemRData=0xFFFFFFFF. Required: next cycle MemReq=0 and CReadData1=0; with ARB_IBUF_EN, buffer valid=0; stall=1.
- CRead0=CWrite0=1 at 0x8. Required: MemWe=1.
